// File: rtl/usb_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : usb_defs                                                     |
// | Description : Shared USB definitions: endpoint address width and the       |
// |               state encoding of the bulk-IN arbiter transfer FSM.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package usb_defs;

    // USB endpoint address width
    localparam int c_EP_W = 4;

    // Bulk-IN arbiter transfer state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,     // waiting for a bulk IN transfer to start
        ST_SEND = 2'd1,     // streaming the selected source to usb_xfer
        ST_HOLD = 2'd2      // packet done or endpoint unmapped; wait for xfer end
    } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_bulk_in_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_bulk_in_arbiter                                          |
// | Description : Shares the single bulk-IN source port of usb_xfer (bid_*)    |
// |               between NUM_SRC on-chip packet sources, each bound to one    |
// |               endpoint address. The host-selected endpoint's stream is     |
// |               steered to usb_xfer for exactly one packet per IN transfer;  |
// |               completion or mid-packet abort is reported per source.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clock, reset_n        usb clock, asynchronous active-low reset           |
// |   blk_xfer_endpoint_i   endpoint of the current bulk transfer              |
// |   blk_in_xfer_i         bulk IN transfer in progress                       |
// |   src_has_data_i        per source: holds at least one complete packet     |
// |   src_tvalid/tready/tlast/tdata  per-source AXI-S streams                  |
// |   src_sent_o            1-cycle pulse: packet fully handed to usb_xfer     |
// |   src_abort_o           1-cycle pulse: transfer ended mid-packet, rewind   |
// |   bid_*                 AXI-S stream plus has_data flag towards usb_xfer   |
// |   busy_o                arbiter not idle                                   |
// +----------------------------------------------------------------------------+
module usb_bulk_in_arbiter
    import usb_defs::*;
#(
    parameter int                   NUM_SRC = 4,
    parameter logic [4*NUM_SRC-1:0] EP_MAP  = 16'h4321
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [c_EP_W-1:0]    blk_xfer_endpoint_i,
    input  logic                 blk_in_xfer_i,
    input  logic [NUM_SRC-1:0]   src_has_data_i,
    input  logic [NUM_SRC-1:0]   src_tvalid_i,
    output logic [NUM_SRC-1:0]   src_tready_o,
    input  logic [NUM_SRC-1:0]   src_tlast_i,
    input  logic [8*NUM_SRC-1:0] src_tdata_i,
    output logic [NUM_SRC-1:0]   src_sent_o,
    output logic [NUM_SRC-1:0]   src_abort_o,
    output logic                 bid_has_data_o,
    output logic                 bid_tvalid_o,
    input  logic                 bid_tready_i,
    output logic                 bid_tlast_o,
    output logic [7:0]           bid_tdata_o,
    output logic                 busy_o
);

    localparam int c_SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    xfer_state_t          r_state;
    xfer_state_t          w_next_state;
    logic [c_SEL_W-1:0]   r_sel;
    logic [c_SEL_W-1:0]   w_idx;
    logic [NUM_SRC-1:0]   w_match;
    logic                 w_hit;
    logic [7:0]           w_data [NUM_SRC];
    logic                 r_xfer_prev;
    logic                 w_rise;
    logic                 r_beat_taken;
    logic                 r_has_data;
    logic                 w_has_data_d;
    logic                 w_hs;
    logic                 w_latch_sel;
    logic                 w_sent_set;
    logic                 w_abort_set;
    logic [NUM_SRC-1:0]   w_sel_onehot;
    logic [NUM_SRC-1:0]   r_sent;
    logic [NUM_SRC-1:0]   r_abort;

    // ------------------------------------------------------------------
    // Endpoint lookup and per-source data unpacking
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lookup
        assign w_match[gi] = (EP_MAP[c_EP_W*gi +: c_EP_W] == blk_xfer_endpoint_i);
        assign w_data[gi]  = src_tdata_i[8*gi +: 8];
    end

    // Endpoint addresses are unique, so at most one match bit is set.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_match[i]) begin
                w_idx = c_SEL_W'(i);
            end
        end
    end

    assign w_hit        = |w_match;
    assign w_rise       = blk_in_xfer_i & ~r_xfer_prev;
    assign w_sel_onehot = NUM_SRC'(1) << r_sel;

    // ------------------------------------------------------------------
    // Next-state logic and the combinational stream mux
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_latch_sel  = 1'b0;
        w_sent_set   = 1'b0;
        w_abort_set  = 1'b0;
        w_hs         = 1'b0;
        w_has_data_d = 1'b0;
        bid_tvalid_o = 1'b0;
        bid_tlast_o  = 1'b0;
        bid_tdata_o  = '0;
        src_tready_o = '0;

        case (r_state)
            ST_IDLE: begin
                w_has_data_d = w_hit & src_has_data_i[w_idx];
                if (w_rise) begin
                    if (w_hit) begin
                        w_next_state = ST_SEND;
                        w_latch_sel  = 1'b1;
                    end else begin
                        // Unmapped endpoint: has_data stays low so usb_xfer NAKs.
                        w_next_state = ST_HOLD;
                    end
                end
            end

            ST_SEND: begin
                w_has_data_d         = src_has_data_i[r_sel];
                bid_tvalid_o         = src_tvalid_i[r_sel];
                bid_tlast_o          = src_tlast_i[r_sel];
                bid_tdata_o          = w_data[r_sel];
                src_tready_o[r_sel]  = bid_tready_i;
                w_hs                 = src_tvalid_i[r_sel] & bid_tready_i;
                // A completed last beat takes priority over the transfer ending
                // in the same cycle: the packet was delivered.
                if (w_hs && src_tlast_i[r_sel]) begin
                    w_sent_set   = 1'b1;
                    w_next_state = blk_in_xfer_i ? ST_HOLD : ST_IDLE;
                end else if (!blk_in_xfer_i) begin
                    // Nothing consumed means a plain NAK; the source keeps its packet.
                    w_abort_set  = r_beat_taken | w_hs;
                    w_next_state = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (!blk_in_xfer_i) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sel        <= '0;
            r_xfer_prev  <= 1'b0;
            r_beat_taken <= 1'b0;
            r_has_data   <= 1'b0;
            r_sent       <= '0;
            r_abort      <= '0;
        end else begin
            r_xfer_prev <= blk_in_xfer_i;
            r_has_data  <= w_has_data_d;
            r_sent      <= w_sent_set  ? w_sel_onehot : '0;
            r_abort     <= w_abort_set ? w_sel_onehot : '0;
            // The selection only moves on entry to SEND, so endpoint changes
            // during a transfer cannot redirect the stream.
            if (w_latch_sel) begin
                r_sel <= w_idx;
            end
            if (r_state == ST_SEND) begin
                if (w_hs) begin
                    r_beat_taken <= 1'b1;
                end
            end else begin
                r_beat_taken <= 1'b0;
            end
        end
    end

    assign src_sent_o     = r_sent;
    assign src_abort_o    = r_abort;
    assign bid_has_data_o = r_has_data;
    assign busy_o         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_bulk_in_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_usb_bulk_in_arbiter                                       |
// | Description : Self-checking bench for usb_bulk_in_arbiter. Sources and     |
// |               the usb_xfer side are modelled at transfer level; expected   |
// |               stream, pulses and beat counts come from endpoint lookup     |
// |               and packet lengths.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_usb_bulk_in_arbiter;

    localparam int          NSRC = 4;
    localparam logic [15:0] MAP  = 16'h4321;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  blk_xfer_endpoint_i;
    logic        blk_in_xfer_i;
    logic [3:0]  src_has_data_i;
    logic [3:0]  src_tvalid_i;
    logic [3:0]  src_tready_o;
    logic [3:0]  src_tlast_i;
    logic [31:0] src_tdata_i;
    logic [3:0]  src_sent_o;
    logic [3:0]  src_abort_o;
    logic        bid_has_data_o;
    logic        bid_tvalid_o;
    logic        bid_tready_i;
    logic        bid_tlast_o;
    logic [7:0]  bid_tdata_o;
    logic        busy_o;

    usb_bulk_in_arbiter #(
        .NUM_SRC (NSRC),
        .EP_MAP  (MAP)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .blk_xfer_endpoint_i (blk_xfer_endpoint_i),
        .blk_in_xfer_i       (blk_in_xfer_i),
        .src_has_data_i      (src_has_data_i),
        .src_tvalid_i        (src_tvalid_i),
        .src_tready_o        (src_tready_o),
        .src_tlast_i         (src_tlast_i),
        .src_tdata_i         (src_tdata_i),
        .src_sent_o          (src_sent_o),
        .src_abort_o         (src_abort_o),
        .bid_has_data_o      (bid_has_data_o),
        .bid_tvalid_o        (bid_tvalid_o),
        .bid_tready_i        (bid_tready_i),
        .bid_tlast_o         (bid_tlast_o),
        .bid_tdata_o         (bid_tdata_o),
        .busy_o              (busy_o)
    );

    always #5 clock = ~clock;

    int         errors = 0;
    int         checks = 0;
    int         cnt [NSRC];
    int         len [NSRC];
    logic [7:0] base [NSRC];
    logic [3:0] has_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which source owns an endpoint, -1 when unmapped.
    function automatic int ep_to_src(input int ep);
        logic [15:0] m;
        m = MAP;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(m[4*i +: 4]) == ep) return i;
        end
        return -1;
    endfunction

    // Sources present their current beat; tvalid has random bubbles unless forced.
    task automatic drive_sources(input int force_idx);
        for (int i = 0; i < NSRC; i++) begin
            src_tvalid_i[i]        = has_data[i] && ((i == force_idx) || ($urandom_range(0, 4) != 0));
            src_tlast_i[i]         = (cnt[i] == len[i] - 1);
            src_tdata_i[8*i +: 8]  = 8'(base[i] + 8'(cnt[i]));
        end
        src_has_data_i = has_data;
    endtask

    // One IN transfer. drop_beats<0: never end early; otherwise end after that
    // many beats. same_cycle: end the transfer on the last-beat handshake.
    task automatic run_xfer(input int ep, input int drop_beats, input bit same_cycle, output int beats);
        int tgt, phase, cyc;
        bit rdy, drop, hs, last, done, fv, exp_valid;
        logic [3:0] exp_sent, exp_abort, exp_rdy;
        tgt = ep_to_src(ep);
        for (int i = 0; i < NSRC; i++) begin
            cnt[i]  = 0;
            base[i] = 8'($urandom);
        end
        blk_xfer_endpoint_i = 4'(ep);
        blk_in_xfer_i       = 1'b0;
        bid_tready_i        = 1'b0;
        drive_sources(-1);
        @(posedge clock); #1;
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_has_data", 32'(bid_has_data_o), (tgt >= 0) ? 32'(has_data[tgt]) : 0);
        blk_in_xfer_i = 1'b1;
        @(posedge clock); #1;
        chk("start_has_data", 32'(bid_has_data_o), (tgt >= 0) ? 32'(has_data[tgt]) : 0);

        phase = (tgt >= 0) ? 1 : 2;   // 1 streaming, 2 holding, 0 finished
        exp_sent = '0; exp_abort = '0;
        cyc = 0; beats = 0; done = 0;
        while (!done && cyc < 300) begin
            rdy = 0; drop = 0; fv = 0;
            if (phase == 1) begin
                if (same_cycle && has_data[tgt] && cnt[tgt] == len[tgt] - 1) begin
                    rdy = 1; drop = 1; fv = 1;
                end else if (drop_beats >= 0 && beats >= drop_beats && cyc >= 2) begin
                    drop = 1;
                end else begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
                blk_xfer_endpoint_i = 4'($urandom_range(0, 15));
            end else if (phase == 2) begin
                drop = (cyc >= 3);
            end else begin
                drop = 1;
            end
            blk_in_xfer_i = !drop;
            bid_tready_i  = rdy;
            drive_sources(fv ? tgt : -1);

            @(negedge clock);
            exp_valid = (phase == 1) ? src_tvalid_i[tgt] : 1'b0;
            exp_rdy   = (phase == 1 && rdy) ? 4'(1 << tgt) : 4'b0;
            chk("busy", 32'(busy_o), 32'(phase != 0));
            chk("sent", 32'(src_sent_o), 32'(exp_sent));
            chk("abort", 32'(src_abort_o), 32'(exp_abort));
            chk("bid_tvalid", 32'(bid_tvalid_o), 32'(exp_valid));
            chk("src_tready", 32'(src_tready_o), 32'(exp_rdy));
            if (exp_valid) begin
                chk("bid_tdata", 32'(bid_tdata_o), 32'(8'(base[tgt] + 8'(cnt[tgt]))));
                chk("bid_tlast", 32'(bid_tlast_o), 32'(cnt[tgt] == len[tgt] - 1));
            end else if (phase != 1) begin
                chk("idle_tlast", 32'(bid_tlast_o), 0);
            end

            hs   = exp_valid && rdy;
            last = hs && (cnt[tgt] == len[tgt] - 1);
            exp_sent = '0; exp_abort = '0;
            case (phase)
                1: begin
                    if (hs) beats++;
                    if (last) begin
                        exp_sent = 4'(1 << tgt);
                        phase    = drop ? 0 : 2;
                    end else begin
                        if (hs) cnt[tgt]++;
                        if (drop) begin
                            if (beats > 0) exp_abort = 4'(1 << tgt);
                            phase = 0;
                        end
                    end
                end
                2: if (drop) phase = 0;
                default: done = 1;
            endcase
            cyc++;
            @(posedge clock); #1;
        end
        chk("xfer_done", 32'(done), 1);
        @(negedge clock);
        chk("pulse_width_sent", 32'(src_sent_o), 0);
        chk("pulse_width_abort", 32'(src_abort_o), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, ep, tgt, mode, d;
        bit same;
        reset_n = 1'b0;
        blk_xfer_endpoint_i = '0; blk_in_xfer_i = 1'b0; bid_tready_i = 1'b0;
        src_has_data_i = '0; src_tvalid_i = '0; src_tlast_i = '0; src_tdata_i = '0;
        has_data = '0;
        for (int i = 0; i < NSRC; i++) begin cnt[i] = 0; len[i] = 1; base[i] = '0; end
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_has_data", 32'(bid_has_data_o), 0);
        chk("rst_tvalid", 32'(bid_tvalid_o), 0);
        chk("rst_tready", 32'(src_tready_o), 0);
        chk("rst_sent_abort", 32'({src_sent_o, src_abort_o}), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // EP2 -> source 1, 4-byte packet delivered whole
        has_data = 4'b0010; len[1] = 4;
        run_xfer(2, -1, 0, beats);
        chk("ep2_beats", 32'(beats), 4);

        // EP3 with no data: NAK, then served once data arrives
        has_data = 4'b0000;
        run_xfer(3, 0, 0, beats);
        chk("ep3_nak_beats", 32'(beats), 0);
        has_data = 4'b0100; len[2] = 5;
        run_xfer(3, -1, 0, beats);
        chk("ep3_served_beats", 32'(beats), 5);

        // EP9 unmapped
        has_data = 4'b1111;
        run_xfer(9, -1, 0, beats);
        chk("ep9_beats", 32'(beats), 0);

        // EP1, transfer ends after 2 of 8 beats
        has_data = 4'b0001; len[0] = 8;
        run_xfer(1, 2, 0, beats);
        chk("ep1_abort_beats", 32'(beats), 2);

        // EP4, last beat coincides with transfer end
        has_data = 4'b1000; len[3] = 3;
        run_xfer(4, -1, 1, beats);
        chk("ep4_same_beats", 32'(beats), 3);

        // Reset in the middle of a packet
        has_data = 4'b0001; len[0] = 8;
        for (int i = 0; i < NSRC; i++) cnt[i] = 0;
        blk_xfer_endpoint_i = 4'd1; drive_sources(0);
        @(posedge clock); #1;
        blk_in_xfer_i = 1'b1;
        @(posedge clock); #1;
        bid_tready_i = 1'b1; drive_sources(0);
        @(negedge clock);
        chk("rst_pre_valid", 32'(bid_tvalid_o), 1);
        chk("rst_pre_ready", 32'(src_tready_o), 32'(4'b0001));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_tvalid", 32'(bid_tvalid_o), 0);
        chk("arst_tready", 32'(src_tready_o), 0);
        chk("arst_has_data", 32'(bid_has_data_o), 0);
        @(posedge clock); #1;
        blk_in_xfer_i = 1'b0; bid_tready_i = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("arst_no_abort", 32'(src_abort_o), 0);
        chk("arst_no_sent", 32'(src_sent_o), 0);
        run_xfer(1, -1, 0, beats);
        chk("post_rst_beats", 32'(beats), 8);

        // Randomised transfers
        for (int k = 0; k < 40; k++) begin
            ep = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 15));
            has_data = 4'($urandom);
            for (int i = 0; i < NSRC; i++) len[i] = $urandom_range(1, 8);
            tgt  = ep_to_src(ep);
            mode = $urandom_range(0, 3);
            d = -1; same = 0;
            if (tgt >= 0) begin
                if (mode == 1 && len[tgt] >= 2) d = $urandom_range(1, len[tgt] - 1);
                if (mode == 2) same = 1;
                if (mode == 3) has_data[tgt] = 1'b0;
                if (!has_data[tgt]) d = 0;
            end
            run_xfer(ep, d, same, beats);
            if (tgt < 0 || !has_data[tgt]) chk("rnd_beats", 32'(beats), 0);
            else if (d > 0) chk("rnd_beats", 32'(beats), 32'(d));
            else chk("rnd_beats", 32'(beats), 32'(len[tgt]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
